// File: rtl/ldpc_din_if.sv
// Bundle between ldpc_din, the demapper (LLR stream), the decoder controller
// (busy / sync / done) and the channel RAM write port.
interface ldpc_din_if #(
  parameter int LLR_IN_W = 8,
  parameter int LLR_W    = 6,
  parameter int LANES    = 12,
  parameter int AW       = 10
);
  logic                   frame_start;
  logic                   llr_valid;
  logic [LLR_IN_W-1:0]    llr_in;
  logic                   llr_ready;
  logic                   dec_busy;
  logic                   ram_we;
  logic [AW-1:0]          ram_addr;
  logic [LANES*LLR_W-1:0] ram_wdata;
  logic                   sync_out;
  logic                   frame_done;
  logic                   err_resync;
  logic                   err_nosync;

  // Environment side: demapper, controller and RAM.
  modport master (
    output frame_start, llr_valid, llr_in, dec_busy,
    input  llr_ready, ram_we, ram_addr, ram_wdata, sync_out, frame_done,
           err_resync, err_nosync
  );

  // Packer side.
  modport slave (
    input  frame_start, llr_valid, llr_in, dec_busy,
    output llr_ready, ram_we, ram_addr, ram_wdata, sync_out, frame_done,
           err_resync, err_nosync
  );
endinterface

// File: rtl/ldpc_din.sv
// LLR input packer: saturates samples, packs LANES per channel-RAM word, frames
// WORDS words per codeword. Define LDPC_DIN_SAT_EN for symmetric saturation.
module ldpc_din #(
  parameter int LLR_IN_W = 8,
  parameter int LLR_W    = 6,
  parameter int LANES    = 12,
  parameter int WORDS    = 768,
  parameter int AW       = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  ldpc_din_if.slave    io
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DW = LANES * LLR_W;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e           state_q, state_d;
  logic             ready, accept;
  logic [LLR_W-1:0] llr_s;
  logic [LW-1:0]    lane_q, lane_d;
  logic [AW-1:0]    word_q, word_d;
  logic [DW-1:0]    pack_q, pack_d;
  logic             ram_we_q, ram_we_d;
  logic [AW-1:0]    ram_addr_q, ram_addr_d;
  logic [DW-1:0]    ram_wdata_q, ram_wdata_d;
  logic             sync_q, sync_d;
  logic             done_q, done_d;
  logic             err_resync_q, err_resync_d;
  logic             err_nosync_q, err_nosync_d;

`ifdef LDPC_DIN_SAT_EN
  localparam logic signed [LLR_IN_W-1:0] MAXV = LLR_IN_W'((1 << (LLR_W - 1)) - 1);
  localparam logic signed [LLR_IN_W-1:0] MINV = -MAXV;

  // Symmetric clamp keeps the most-negative code out of the decoder.
  function automatic logic [LLR_W-1:0] sat(input logic signed [LLR_IN_W-1:0] x);
    if (x > MAXV)      return MAXV[LLR_W-1:0];
    else if (x < MINV) return MINV[LLR_W-1:0];
    else               return x[LLR_W-1:0];
  endfunction
`else
  function automatic logic [LLR_W-1:0] sat(input logic [LLR_IN_W-1:0] x);
    return x[LLR_W-1:0];
  endfunction
`endif

  assign llr_s = sat(io.llr_in);

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every signal written in an always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && io.frame_start) state_d = LOAD;
      LOAD:    if (accept && !io.frame_start && lane_q == LAST_LANE &&
                   word_q == LAST_WORD) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: dec_busy only matters while waiting for a frame.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      IDLE:    ready = !io.dec_busy;
      LOAD:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
    accept = io.llr_valid && ready;
  end

  // Datapath: lane packing, word addressing, framing and error flags.
  always_comb begin
    lane_d       = lane_q;
    word_d       = word_q;
    pack_d       = pack_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    sync_d       = sync_q;
    done_d       = 1'b0;
    err_resync_d = err_resync_q;
    err_nosync_d = err_nosync_q;
    if (state_q == DONE) begin
      sync_d = 1'b0;
      done_d = 1'b1;
    end else if (accept) begin
      if (io.frame_start) begin
        // Fresh frame or restart: the partial word is dropped, never written.
        err_resync_d        = err_resync_q || (state_q == LOAD);
        pack_d[LLR_W-1:0]   = llr_s;
        lane_d              = LW'(1);
        word_d              = '0;
        sync_d              = 1'b1;
      end else if (state_q == IDLE) begin
        err_nosync_d = 1'b1;
      end else begin
        pack_d[lane_q*LLR_W +: LLR_W] = llr_s;
        if (lane_q == LAST_LANE) begin
          lane_d      = '0;
          ram_we_d    = 1'b1;
          ram_addr_d  = word_q;
          ram_wdata_d = pack_d;
          word_d      = (word_q == LAST_WORD) ? '0 : word_q + AW'(1);
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q       <= '0;
      word_q       <= '0;
      pack_q       <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      sync_q       <= 1'b0;
      done_q       <= 1'b0;
      err_resync_q <= 1'b0;
      err_nosync_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      word_q       <= word_d;
      pack_q       <= pack_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      sync_q       <= sync_d;
      done_q       <= done_d;
      err_resync_q <= err_resync_d;
      err_nosync_q <= err_nosync_d;
    end
  end

  assign io.llr_ready  = ready;
  assign io.ram_we     = ram_we_q;
  assign io.ram_addr   = ram_addr_q;
  assign io.ram_wdata  = ram_wdata_q;
  assign io.sync_out   = sync_q;
  assign io.frame_done = done_q;
  assign io.err_resync = err_resync_q;
  assign io.err_nosync = err_nosync_q;
endmodule
